ropuf_array_top: RTL

Parametrised ring-oscillator PUF measurement block, the next generation of the fixed 34-bit, two-bit-cell RO PUF top. It drives NUM_PAIRS oscillator pairs and counts their edges over a programmable clock window. It compares each pair to produce a per-pair response vector, a tie vector and the legacy XOR-reduced bit. Start/busy/valid handshake; sits between the RO hard-macro array and the challenge/response controller.

---
 rtl/ropuf_pkg.sv | 27 ++
 rtl/ropuf_pair_counter.sv | 58 +++++
 rtl/ropuf_array_top.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ropuf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF array.
// Covers the FSM states, flush length and challenge bit layout.
package ropuf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    // Cycles needed to push a level through the synchroniser plus edge flop.
    function automatic int unsigned flush_len(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

    function automatic int unsigned swap_bit(input int unsigned pair);
        return 2 * pair;
    endfunction

    function automatic int unsigned en_bit(input int unsigned pair);
        return 2 * pair + 1;
    endfunction

endpackage

// File: rtl/ropuf_pair_counter.sv
// One oscillator pair: synchronise, edge-count with saturation,
// then compare the two counts after the optional A/B swap.
module ropuf_pair_counter
    import ropuf_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       cnt_en,
    input  logic       pair_en,
    input  logic       swap,
    input  logic [1:0] ro_in,
    output logic       resp,
    output logic       tie
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true" *)
    logic [SYNC_STAGES-1:0][1:0] sync;
    logic [1:0]                  prev;
    logic [1:0]                  rise;
    logic [COUNT_W-1:0]          cnt [2];
    logic [COUNT_W-1:0]          cnt_a;
    logic [COUNT_W-1:0]          cnt_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset || clr) begin
                cnt[k] <= '0;
            end else if (cnt_en && pair_en && rise[k] &&
                         cnt[k] != CNT_MAX) begin
                cnt[k] <= cnt[k] + COUNT_W'(1);
            end
        end
    end

    assign cnt_a = swap ? cnt[1] : cnt[0];
    assign cnt_b = swap ? cnt[0] : cnt[1];
    assign resp  = pair_en && (cnt_a > cnt_b);
    assign tie   = pair_en && (cnt_a == cnt_b);

endmodule

// File: rtl/ropuf_array_top.sv
// RO PUF array top: measurement FSM, window timer, challenge latch
// and registered per-pair results with the legacy XOR bit.
module ropuf_array_top
    import ropuf_pkg::*;
#(
    parameter int NUM_PAIRS   = 17,
    parameter int COUNT_W     = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [2*NUM_PAIRS-1:0] chal,
    input  logic [WIN_W-1:0]       window,
    input  logic [2*NUM_PAIRS-1:0] ro_in,
    output logic [2*NUM_PAIRS-1:0] ro_en,
    output logic                   busy,
    output logic                   resp_valid,
    output logic [NUM_PAIRS-1:0]   resp_vec,
    output logic [NUM_PAIRS-1:0]   tie_vec,
    output logic                   resp
);

    localparam int unsigned      FLUSH      = flush_len(SYNC_STAGES);
    localparam logic [WIN_W-1:0] FLUSH_LAST = WIN_W'(FLUSH - 1);

    state_t                 state;
    state_t                 nxt;
    logic [WIN_W-1:0]       tmr;
    logic [WIN_W-1:0]       tmr_nxt;
    logic [WIN_W-1:0]       win_q;
    logic [2*NUM_PAIRS-1:0] chal_q;
    logic                   clr;
    logic                   cap;
    logic                   cnt_en;
    logic                   run;
    logic [NUM_PAIRS-1:0]   rv;
    logic [NUM_PAIRS-1:0]   tv;

    (* keep = "true", dont_touch = "true" *)
    logic [2*NUM_PAIRS-1:0] ro_en_w;
    (* keep = "true", dont_touch = "true" *)
    logic [2*NUM_PAIRS-1:0] ro_in_w;

    assign ro_in_w = ro_in;
    assign ro_en   = ro_en_w;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chal_q <= '0;
            win_q  <= '0;
        end else if (clr) begin
            chal_q <= chal;
            win_q  <= (window == '0) ? WIN_W'(1) : window;
        end
    end

    always_comb begin
        nxt     = state;
        tmr_nxt = tmr;
        clr     = 1'b0;
        cap     = 1'b0;
        if (state != S_IDLE && !enable) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && enable) begin
                        nxt     = S_SETTLE;
                        tmr_nxt = FLUSH_LAST;
                        clr     = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (tmr == '0) begin
                        nxt     = S_COUNT;
                        tmr_nxt = win_q - WIN_W'(1);
                    end else begin
                        tmr_nxt = tmr - WIN_W'(1);
                    end
                end
                S_COUNT: begin
                    if (tmr == '0) begin
                        nxt     = S_DRAIN;
                        tmr_nxt = FLUSH_LAST;
                    end else begin
                        tmr_nxt = tmr - WIN_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (tmr == '0) begin
                        nxt = S_COMPARE;
                    end else begin
                        tmr_nxt = tmr - WIN_W'(1);
                    end
                end
                S_COMPARE: begin
                    nxt = S_DONE;
                    cap = 1'b1;
                end
                S_DONE: nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Draining keeps counting after the oscillators stop.
    assign cnt_en     = (state == S_COUNT) || (state == S_DRAIN);
    assign run        = (state == S_SETTLE) || (state == S_COUNT);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign resp_valid = (state == S_DONE);

    for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
        assign ro_en_w[2*i +: 2] = {2{run & chal_q[en_bit(i)]}};

        ropuf_pair_counter #(
            .COUNT_W     (COUNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_pc (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .cnt_en  (cnt_en),
            .pair_en (chal_q[en_bit(i)]),
            .swap    (chal_q[swap_bit(i)]),
            .ro_in   (ro_in_w[2*i +: 2]),
            .resp    (rv[i]),
            .tie     (tv[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_vec <= '0;
            tie_vec  <= '0;
            resp     <= 1'b0;
        end else if (cap) begin
            resp_vec <= rv;
            tie_vec  <= tv;
            resp     <= ^rv;
        end
    end

endmodule
